// File: rtl/traffic_phase_ctrl.sv
// Four-way traffic-light phase controller: NS-green/yellow, EW-green/yellow on a 1 s tick.
// Optional night flashing mode is built when NIGHT_FLASH_EN is defined.
module traffic_phase_ctrl #(
  parameter int unsigned TICK_CNT = 50_000_000,
  parameter int unsigned G_TIME   = 27,
  parameter int unsigned Y_TIME   = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
`ifdef NIGHT_FLASH_EN
  input  logic       night,
`endif
  input  logic       hold,
  output logic [9:0] n_time,
  output logic [9:0] e_time,
  output logic [9:0] s_time,
  output logic [9:0] w_time,
  output logic       en,
  output logic [2:0] ns_led,
  output logic [2:0] ew_led
);

  localparam int unsigned TW = (TICK_CNT > 2) ? $clog2(TICK_CNT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CNT - 1);
  localparam logic [6:0] G_LEN = 7'(G_TIME);
  localparam logic [6:0] Y_LEN = 7'(Y_TIME);

  localparam logic [1:0] NS_G = 2'd0;
  localparam logic [1:0] NS_Y = 2'd1;
  localparam logic [1:0] EW_G = 2'd2;
  localparam logic [1:0] EW_Y = 2'd3;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]    state_q, state_d;
  logic [6:0]    phase_cnt_q, phase_cnt_d;
  logic          en_q;
  logic          tick_wrap, tick;
  logic [6:0]    ns_val, ew_val, phase_plus;
  logic [2:0]    ns_lamp, ew_lamp;

`ifdef NIGHT_FLASH_EN
  logic flash_q, flash_d;
`endif

  assign tick_wrap = (tick_cnt_q == TICK_LAST);
  assign tick      = tick_wrap & ~hold;

  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    if (!hold) begin
      tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;
    end
    if (tick) begin
      if (phase_cnt_q == 7'd1) begin
        unique case (state_q)
          NS_G:    begin state_d = NS_Y; phase_cnt_d = Y_LEN; end
          NS_Y:    begin state_d = EW_G; phase_cnt_d = G_LEN; end
          EW_G:    begin state_d = EW_Y; phase_cnt_d = Y_LEN; end
          default: begin state_d = NS_G; phase_cnt_d = G_LEN; end
        endcase
      end else begin
        phase_cnt_d = phase_cnt_q - 1'b1;
      end
    end
`ifdef NIGHT_FLASH_EN
    flash_d = 1'b1;
    // Night overrides hold: the tick counter keeps running to pace the flashing.
    if (night) begin
      tick_cnt_d  = tick_wrap ? '0 : tick_cnt_q + 1'b1;
      state_d     = NS_G;
      phase_cnt_d = G_LEN;
      flash_d     = tick_wrap ? ~flash_q : flash_q;
    end
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_cnt_q  <= '0;
      state_q     <= NS_G;
      phase_cnt_q <= G_LEN;
      en_q        <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      en_q        <= 1'b1;
    end
  end

`ifdef NIGHT_FLASH_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      flash_q <= 1'b1;
    end else begin
      flash_q <= flash_d;
    end
  end
`endif

  assign phase_plus = phase_cnt_q + Y_LEN;

  always_comb begin
    ns_lamp = 3'b001;
    ew_lamp = 3'b100;
    ns_val  = phase_cnt_q;
    ew_val  = phase_plus;
    unique case (state_q)
      NS_G: begin ns_lamp = 3'b001; ew_lamp = 3'b100; ns_val = phase_cnt_q; ew_val = phase_plus; end
      NS_Y: begin ns_lamp = 3'b010; ew_lamp = 3'b100; ns_val = phase_cnt_q; ew_val = phase_cnt_q; end
      EW_G: begin ns_lamp = 3'b100; ew_lamp = 3'b001; ns_val = phase_plus; ew_val = phase_cnt_q; end
      default: begin
        ns_lamp = 3'b100; ew_lamp = 3'b010; ns_val = phase_cnt_q; ew_val = phase_cnt_q;
      end
    endcase
  end

`ifdef NIGHT_FLASH_EN
  always_comb begin
    if (night) begin
      n_time = '0;
      s_time = '0;
      e_time = '0;
      w_time = '0;
      en     = 1'b0;
      ns_led = {1'b0, flash_q, 1'b0};
      ew_led = {1'b0, flash_q, 1'b0};
    end else begin
      n_time = {3'b000, ns_val};
      s_time = {3'b000, ns_val};
      e_time = {3'b000, ew_val};
      w_time = {3'b000, ew_val};
      en     = en_q;
      ns_led = ns_lamp;
      ew_led = ew_lamp;
    end
  end
`else
  assign n_time = {3'b000, ns_val};
  assign s_time = {3'b000, ns_val};
  assign e_time = {3'b000, ew_val};
  assign w_time = {3'b000, ew_val};
  assign en     = en_q;
  assign ns_led = ns_lamp;
  assign ew_led = ew_lamp;
`endif

endmodule
